phy_link_ctrl: RTL and testbench
================================

// Module: phy_link_ctrl
// PURPOSE
// Link-layer controller for the 4-lane PHY transmit path, on the clk_f domain.
// Brings the link up (training idles, waits for receiver lock), then schedules the lane FIFOs
// onto the shared serializer input with a round-robin arbiter.
// Honours per-lane downstream back-pressure and drops to ERROR on loss of lock.
// PARAMETERS
// NUM_LANES    4   requesting lanes, 2..8; lane_sel width = clog2(NUM_LANES)
// TRAIN_WORDS  16  idle (0xBC) words sent in INIT before lock is accepted, >=1
// LOSS_MAX     4   consecutive cycles of active_rx=0 tolerated in IDLE/ACTIVE
// CNT_W        16  width of each statistics counter (LINK_STATS_EN only)
// PORTS
// clk_f      in   1               single clock; all state on posedge
// reset_L    in   1               asynchronous, active-low reset
// init       in   1               1-cycle pulse: restart training from ERROR or IDLE
// active_rx  in   1               receiver lock indication
// fifo_empty in   NUM_LANES       per-lane source FIFO empty
// dst_af     in   NUM_LANES       per-lane downstream almost-full (back-pressure)
// pop        out  NUM_LANES       one-hot FIFO read strobe, combinational
// lane_sel   out  clog2(NUM_LANES) serializer mux select, registered
// data_valid out  1               lane_sel/FIFO data valid this cycle, registered
// send_idle  out  1               serializer must emit 0xBC this cycle, registered
// active     out  1               state==ACTIVE, registered
// idle_out   out  1               state==IDLE, registered
// state      out  3               current FSM state encoding
// stat_cnt   out  NUM_LANES*CNT_W per-lane words-sent counters; lane i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
// Reset (reset_L=0, asynchronous): state=RESET, pop=0, lane_sel=0, data_valid=0,
//   send_idle=0, active=0, idle_out=0, rr pointer=NUM_LANES-1, counters=0.
// FSM, encodings RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4:
//   RESET->INIT on the first clock edge after reset_L=1.
//   INIT: send_idle=1; train counter counts to TRAIN_WORDS; ->IDLE when count done AND active_rx=1.
//   IDLE: send_idle=1; ->ACTIVE when any lane is eligible.
//   ACTIVE: ->IDLE when no lane is eligible. A 1-cycle idle word goes out between bursts.
//   IDLE/ACTIVE: loss counter increments while active_rx=0 and clears when active_rx=1.
//     When it reaches LOSS_MAX, ->ERROR, which takes priority over all other transitions.
//   ERROR: pop=0, send_idle=0; leaves only on init=1 (->INIT) or reset.
//   init=1 in IDLE ->INIT. init is ignored in RESET, INIT and ACTIVE.
//   Every entry to INIT clears the train counter and the loss counter.
// Eligible lane i: ~fifo_empty[i] & ~dst_af[i].
// Grant: round-robin over eligible lanes, starting at rr+1 and wrapping modulo NUM_LANES.
//   pop = grant while state==ACTIVE, else 0.
//   rr takes the granted index at the same edge.
// Latency: data_valid=1 and lane_sel=granted index on the cycle after pop.
//   This aligns with registered FIFO read data.
// send_idle is 1 in every INIT/IDLE/ACTIVE cycle with data_valid=0. Never both are 1.
// Back-pressure: dst_af rising masks that lane from the next grant decision.
//   A word already popped is still delivered.
// Single eligible lane: granted every cycle, giving 100% throughput.
// Reset mid-burst: the outstanding pop word is discarded; outputs return to reset values at once.
// CONFIGURATION
// LINK_STATS_EN defined:
//   stat_cnt[i] increments on each data_valid with lane_sel==i.
//   Counters saturate at all-ones and clear on reset and on INIT entry.
// LINK_STATS_EN undefined: stat_cnt is tied to 0 and no counter flops exist.
// STRUCTURE
// phy_ctrl_defs.vh (shared): state encodings, IDLE_SYM=8'hBC.
//   The serializer includes the same file.
// Sub-module rr_arbiter:
//   inputs req[NUM_LANES] and ptr; outputs one-hot gnt, gnt_idx and any.
//   Purely combinational; the FSM, pointer and counters live in phy_link_ctrl.
// TESTING
// 1 Reset release, active_rx=1: state 0->1; 16 cycles send_idle=1; then state=2, idle_out=1.
// 2 active_rx held 0 in INIT: stays INIT indefinitely.
//   active_rx=1 at cycle 30 -> IDLE at cycle 31.
// 3 All 4 lanes non-empty, dst_af=0: pop 0001,0010,0100,1000,0001...
//   data_valid=1 continuous; lane_sel 0,1,2,3 lagging pop by 1.
// 4 Lanes 1,3 eligible, then dst_af[3]=1: grants alternate 1,3.
//   After the mask, only lane 1; lane 3 resumes after dst_af[3]=0.
// 5 In ACTIVE, active_rx=0 for 3 cycles then 1: stays ACTIVE.
//   0 for 4 cycles: state=4, pop=0; init pulse -> INIT, train restarts.
// 6 LINK_STATS_EN, CNT_W=4, 20 words on lane 2: stat_cnt lane2=15 saturated.
//   Without the macro, stat_cnt stays 0.

Source files
------------

// File: rtl/phy_link_ctrl_pkg.sv
// Shared definitions for the PHY link-layer controller: FSM state encodings,
// the idle symbol emitted by the serializer, and small state helpers.
package phy_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } link_state_e;

    // Comma/idle symbol the serializer sends whenever send_idle is high
    localparam logic [7:0] IDLE_SYM = 8'hBC;

    // States in which the serializer is driven (idle words or lane data)
    function automatic logic link_driven(input link_state_e s);
        return (s == ST_INIT) || (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/phy_link_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane found when scanning
// from ptr+1 upward, wrapping modulo NUM_LANES. Purely combinational; the
// pointer itself is held by the caller.
module rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 any
);

    int   idx;
    logic found;

    // Scan lanes in rotating priority order, lowest priority is ptr itself
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = (int'(ptr) + k) % NUM_LANES;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/phy_link_ctrl.sv
// Link-layer controller for the 4-lane PHY transmit path (clk_f domain).
// Trains the link with idle words, waits for receiver lock, then schedules
// the lane FIFOs onto the serializer with a round-robin arbiter.
// Optional feature: define LINK_STATS_EN to build per-lane words-sent
// counters; otherwise stat_cnt is tied to zero and no counter flops exist.
module phy_link_ctrl
    import phy_link_ctrl_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int TRAIN_WORDS = 16,
    parameter int LOSS_MAX    = 4,
    parameter int CNT_W       = 16,
    parameter int IDX_W       = $clog2(NUM_LANES)
) (
    input  logic                       clk_f,
    input  logic                       reset_L,
    input  logic                       init,
    input  logic                       active_rx,
    input  logic [NUM_LANES-1:0]       fifo_empty,
    input  logic [NUM_LANES-1:0]       dst_af,
    output logic [NUM_LANES-1:0]       pop,
    output logic [IDX_W-1:0]           lane_sel,
    output logic                       data_valid,
    output logic                       send_idle,
    output logic                       active,
    output logic                       idle_out,
    output logic [2:0]                 state,
    output logic [NUM_LANES*CNT_W-1:0] stat_cnt
);

    localparam int TW = $clog2(TRAIN_WORDS + 1);
    localparam int LW = $clog2(LOSS_MAX + 1);

    link_state_e            state_q, state_d;
    logic [TW-1:0]          train_cnt_q, train_cnt_d;
    logic [LW-1:0]          loss_cnt_q, loss_cnt_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       lane_sel_q, lane_sel_d;
    logic                   data_valid_q, data_valid_d;
    logic                   send_idle_q, send_idle_d;
    logic                   active_q, active_d;
    logic                   idle_out_q, idle_out_d;

    logic [NUM_LANES-1:0]   eligible;
    logic [NUM_LANES-1:0]   gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   any_elig;
    logic                   pop_any;
    logic                   train_done;
    logic                   loss_hit;
    logic                   enter_init;

    assign eligible = ~fifo_empty & ~dst_af;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req     (eligible),
        .ptr     (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_elig)
    );

    // FIFO reads happen only while ACTIVE; the read data lands next cycle
    assign pop     = (state_q == ST_ACTIVE) ? gnt : '0;
    assign pop_any = (state_q == ST_ACTIVE) && any_elig;

    assign train_done = (train_cnt_q >= TW'(TRAIN_WORDS - 1));
    // Lock loss fires on the cycle the counter would reach LOSS_MAX
    assign loss_hit   = !active_rx && (loss_cnt_q == LW'(LOSS_MAX - 1))
                        && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
    assign enter_init = (state_d == ST_INIT) && (state_q != ST_INIT);

    // State register and all registered outputs
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_RESET;
            train_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            rr_q         <= IDX_W'(NUM_LANES - 1);
            lane_sel_q   <= '0;
            data_valid_q <= 1'b0;
            send_idle_q  <= 1'b0;
            active_q     <= 1'b0;
            idle_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            train_cnt_q  <= train_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            rr_q         <= rr_d;
            lane_sel_q   <= lane_sel_d;
            data_valid_q <= data_valid_d;
            send_idle_q  <= send_idle_d;
            active_q     <= active_d;
            idle_out_q   <= idle_out_d;
        end
    end

    // Next-state logic; lock loss outranks every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (train_done && active_rx) state_d = ST_IDLE;
            ST_IDLE: begin
                if (loss_hit)      state_d = ST_ERROR;
                else if (init)     state_d = ST_INIT;
                else if (any_elig) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (loss_hit)       state_d = ST_ERROR;
                else if (!any_elig) state_d = ST_IDLE;
            end
            ST_ERROR:  if (init) state_d = ST_INIT;
            default:   state_d = ST_RESET;
        endcase
    end

    // Training and lock-loss counters; both restart on every INIT entry
    always_comb begin
        train_cnt_d = train_cnt_q;
        loss_cnt_d  = '0;
        if (state_q == ST_INIT && !train_done) begin
            train_cnt_d = train_cnt_q + 1'b1;
        end
        if ((state_q == ST_IDLE || state_q == ST_ACTIVE) && !active_rx && !loss_hit) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
        if (enter_init) begin
            train_cnt_d = '0;
            loss_cnt_d  = '0;
        end
    end

    // Output decode: data follows the pop by one cycle, idle fills every other driven cycle
    always_comb begin
        data_valid_d = pop_any;
        lane_sel_d   = pop_any ? gnt_idx : lane_sel_q;
        rr_d         = pop_any ? gnt_idx : rr_q;
        send_idle_d  = link_driven(state_d) && !pop_any;
        active_d     = (state_d == ST_ACTIVE);
        idle_out_d   = (state_d == ST_IDLE);
    end

    assign lane_sel   = lane_sel_q;
    assign data_valid = data_valid_q;
    assign send_idle  = send_idle_q;
    assign active     = active_q;
    assign idle_out   = idle_out_q;
    assign state      = state_q;

`ifdef LINK_STATS_EN
    logic [NUM_LANES-1:0][CNT_W-1:0] stat_q, stat_d;

    // Saturating per-lane count of delivered words, cleared on INIT entry
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (enter_init) begin
                stat_d[i] = '0;
            end else if (data_valid_q && (lane_sel_q == IDX_W'(i)) && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + 1'b1;
            end
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Self-checking bench for phy_link_ctrl: a cycle-level rules model runs in
// parallel with the DUT and is compared every cycle, plus literal checks.
module tb_phy_link_ctrl;

    localparam int NL       = 4;
    localparam int TRAIN    = 16;
    localparam int LOSS     = 4;
    localparam int CW       = 4;
    localparam int STAT_MAX = (1 << CW) - 1;

    logic           clk_f;
    logic           reset_L;
    logic           init;
    logic           active_rx;
    logic [NL-1:0]  fifo_empty;
    logic [NL-1:0]  dst_af;
    logic [NL-1:0]  pop;
    logic [1:0]     lane_sel;
    logic           data_valid;
    logic           send_idle;
    logic           active;
    logic           idle_out;
    logic [2:0]     state;
    logic [NL*CW-1:0] stat_cnt;

    int checks = 0;
    int errors = 0;

    phy_link_ctrl #(
        .NUM_LANES   (NL),
        .TRAIN_WORDS (TRAIN),
        .LOSS_MAX    (LOSS),
        .CNT_W       (CW)
    ) dut (
        .clk_f      (clk_f),
        .reset_L    (reset_L),
        .init       (init),
        .active_rx  (active_rx),
        .fifo_empty (fifo_empty),
        .dst_af     (dst_af),
        .pop        (pop),
        .lane_sel   (lane_sel),
        .data_valid (data_valid),
        .send_idle  (send_idle),
        .active     (active),
        .idle_out   (idle_out),
        .state      (state),
        .stat_cnt   (stat_cnt)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    // Model: state as a number 0..4, counters as plain ints
    typedef struct packed {
        logic [2:0]        st;
        int                train;
        int                loss;
        int                rr;
        logic              vld;
        int                sel;
        logic [NL-1:0][31:0] stat;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st    = 3'd0;
        r.train = 0;
        r.loss  = 0;
        r.rr    = NL - 1;
        r.vld   = 1'b0;
        r.sel   = 0;
        r.stat  = '0;
        return r;
    endfunction

    // Lane granted this cycle, or -1 when nothing is read
    function automatic int grant_of(mdl_t s, logic [NL-1:0] emp, logic [NL-1:0] af);
        logic [NL-1:0] el;
        el = ~emp & ~af;
        if (s.st != 3'd3) return -1;
        for (int k = 1; k <= NL; k++) begin
            if (el[(s.rr + k) % NL]) return (s.rr + k) % NL;
        end
        return -1;
    endfunction

    function automatic mdl_t mstep(mdl_t s, logic ini, logic arx,
                                   logic [NL-1:0] emp, logic [NL-1:0] af);
        mdl_t n;
        int g;
        int lossn;
        logic any_el;
        logic to_init;
        n       = s;
        g       = grant_of(s, emp, af);
        any_el  = ((~emp & ~af) != '0);
        to_init = 1'b0;
        if (s.vld && s.stat[s.sel] < STAT_MAX) n.stat[s.sel] = s.stat[s.sel] + 1;
        n.vld = (g >= 0);
        if (g >= 0) begin
            n.sel = g;
            n.rr  = g;
        end
        case (s.st)
            3'd0: begin n.st = 3'd1; to_init = 1'b1; end
            3'd1: begin
                if (s.train >= TRAIN - 1 && arx) n.st = 3'd2;
                else n.train = s.train + 1;
            end
            3'd2, 3'd3: begin
                lossn  = arx ? 0 : s.loss + 1;
                n.loss = lossn;
                if (lossn >= LOSS) n.st = 3'd4;
                else if (s.st == 3'd2 && ini) begin n.st = 3'd1; to_init = 1'b1; end
                else if (s.st == 3'd2 && any_el) n.st = 3'd3;
                else if (s.st == 3'd3 && !any_el) n.st = 3'd2;
            end
            default: if (ini) begin n.st = 3'd1; to_init = 1'b1; end
        endcase
        if (to_init) begin
            n.train = 0;
            n.loss  = 0;
            n.stat  = '0;
        end
        if (n.st != 3'd2 && n.st != 3'd3) n.loss = 0;
        return n;
    endfunction

    // Advance the model with the DUT
    always @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) m <= mdl_reset();
        else          m <= mstep(m, init, active_rx, fifo_empty, dst_af);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    task automatic check_all();
        int g;
        logic [NL-1:0] ep;
        logic [31:0] es;
        g  = grant_of(m, fifo_empty, dst_af);
        ep = '0;
        if (g >= 0) ep[g] = 1'b1;
        chk("pop", 32'(pop), 32'(ep));
        chk("state", 32'(state), 32'(m.st));
        chk("active", 32'(active), 32'(m.st == 3'd3));
        chk("idle_out", 32'(idle_out), 32'(m.st == 3'd2));
        chk("data_valid", 32'(data_valid), 32'(m.vld));
        chk("send_idle", 32'(send_idle),
            32'((m.st == 3'd1 || m.st == 3'd2 || m.st == 3'd3) && !m.vld));
        if (m.vld || m.st == 3'd0) chk("lane_sel", 32'(lane_sel), 32'(m.sel));
        for (int i = 0; i < NL; i++) begin
`ifdef LINK_STATS_EN
            es = m.stat[i];
`else
            es = 0;
`endif
            chk($sformatf("stat_cnt[%0d]", i), 32'(stat_cnt[i*CW +: CW]), es);
        end
    endtask

    task automatic step();
        @(negedge clk_f);
        check_all();
        @(posedge clk_f);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_L    = 1'b1;
        init       = 1'b0;
        active_rx  = 1'b1;
        fifo_empty = '1;
        dst_af     = '0;
        #1 reset_L = 1'b0;
        @(posedge clk_f);
        #2;
        steps(3);
        chk("lit reset state", 32'(state), 0);
        chk("lit reset send_idle", 32'(send_idle), 0);
        chk("lit reset lane_sel", 32'(lane_sel), 0);

        // Training with lock present: 16 INIT cycles then IDLE
        reset_L = 1'b1;
        step();
        chk("lit init entry", 32'(state), 1);
        chk("lit init send_idle", 32'(send_idle), 1);
        steps(15);
        chk("lit init cycle16", 32'(state), 1);
        step();
        chk("lit idle state", 32'(state), 2);
        chk("lit idle_out", 32'(idle_out), 1);

        // Retrain without lock: INIT holds until lock returns at INIT cycle 30
        init      = 1'b1;
        active_rx = 1'b0;
        step();
        init = 1'b0;
        chk("lit retrain init", 32'(state), 1);
        steps(29);
        chk("lit init cycle30", 32'(state), 1);
        active_rx = 1'b1;
        step();
        chk("lit idle after lock", 32'(state), 2);

        // All four lanes eligible: strict rotation
        fifo_empty = 4'b0000;
        step();
        chk("lit rot pop0", 32'(pop), 32'b0001);
        step();
        chk("lit rot pop1", 32'(pop), 32'b0010);
        chk("lit rot sel0", 32'(lane_sel), 0);
        chk("lit rot valid", 32'(data_valid), 1);
        step();
        chk("lit rot pop2", 32'(pop), 32'b0100);
        chk("lit rot sel1", 32'(lane_sel), 1);
        step();
        chk("lit rot pop3", 32'(pop), 32'b1000);
        step();
        chk("lit rot wrap", 32'(pop), 32'b0001);
        chk("lit rot sel3", 32'(lane_sel), 3);

        // Lanes 1 and 3 alternate; mask lane 3 with back-pressure, then release
        fifo_empty = 4'b0101;
        #1 chk("lit alt pop1", 32'(pop), 32'b0010);
        step();
        chk("lit alt pop3", 32'(pop), 32'b1000);
        step();
        dst_af = 4'b1000;
        #1 chk("lit af pop1a", 32'(pop), 32'b0010);
        step();
        chk("lit af pop1b", 32'(pop), 32'b0010);
        step();
        dst_af = 4'b0000;
        #1 chk("lit af resume3", 32'(pop), 32'b1000);
        step();
        fifo_empty = 4'b1111;
        step();
        chk("lit burst end idle", 32'(state), 2);
        chk("lit gap send_idle", 32'(send_idle), 1);

        // init ignored in ACTIVE; short lock dropout tolerated; long one errors
        fifo_empty = 4'b0000;
        step();
        init = 1'b1;
        step();
        init = 1'b0;
        chk("lit init ignored", 32'(state), 3);
        active_rx = 1'b0;
        steps(3);
        active_rx = 1'b1;
        step();
        chk("lit loss3 stays", 32'(state), 3);
        active_rx = 1'b0;
        steps(4);
        chk("lit error state", 32'(state), 4);
        #1 chk("lit error pop", 32'(pop), 0);
        step();
        chk("lit error send_idle", 32'(send_idle), 0);
        chk("lit error valid", 32'(data_valid), 0);
        fifo_empty = 4'b1111;
        active_rx  = 1'b1;
        init       = 1'b1;
        step();
        init = 1'b0;
        chk("lit error to init", 32'(state), 1);
        steps(15);
        chk("lit retrain cycle16", 32'(state), 1);
        step();
        chk("lit retrain idle", 32'(state), 2);

        // Single lane 2: one word every cycle, 20 words total
        fifo_empty = 4'b1011;
        step();
        steps(9);
        chk("lit single pop", 32'(pop), 32'b0100);
        chk("lit single valid", 32'(data_valid), 1);
        steps(11);
        fifo_empty = 4'b1111;
        steps(2);
`ifdef LINK_STATS_EN
        chk("lit stat lane2", 32'(stat_cnt[2*CW +: CW]), 15);
`else
        chk("lit stat lane2", 32'(stat_cnt[2*CW +: CW]), 0);
`endif

        // Reset in the middle of a burst
        fifo_empty = 4'b0000;
        steps(3);
        reset_L = 1'b0;
        #1;
        chk("lit midreset state", 32'(state), 0);
        chk("lit midreset pop", 32'(pop), 0);
        chk("lit midreset valid", 32'(data_valid), 0);
        chk("lit midreset stat", 32'(stat_cnt[2*CW +: CW]), 0);
        steps(2);
        reset_L = 1'b1;
        steps(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
